// File: rtl/xadac_vload_mem_rd.sv
// ---------------------------------------------------------------------------
// xadac_vload_mem_rd
//
// Memory-side read engine that sits directly behind the vector-load unit.
// Each single-beat vector read request is accepted on AR. It is then split
// into N = VecDataWidth/MemDataWidth narrower, in-order memory-bus reads. The
// returned beats are packed into one vector word, which is handed back on R
// with the original id. The engine works on one vector at a time. Up to
// MaxOutstanding memory beats may be in flight at once.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   axi_ar_id/addr     vector read request (id, byte address)
//   axi_ar_valid/ready request handshake; ready only while idle
//   axi_r_id/data      response id and assembled vector
//   axi_r_valid/ready  response handshake
//   mem_req_addr       byte address of the next memory beat
//   mem_req_valid/ready memory beat request handshake
//   mem_rsp_data/valid in-order beat data, no backpressure
// ---------------------------------------------------------------------------

package xadac_pkg;
  localparam int IdWidth      = 4;
  localparam int AddrWidth    = 32;
  localparam int VecDataWidth = 256;

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [AddrWidth-1:0]    AddrT;
  typedef logic [VecDataWidth-1:0] VecDataT;
endpackage

module xadac_vload_mem_rd
  import xadac_pkg::*;
#(
  parameter int MemDataWidth   = 64,
  parameter int MaxOutstanding = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [IdWidth-1:0]      axi_ar_id,
  input  logic [AddrWidth-1:0]    axi_ar_addr,
  input  logic                    axi_ar_valid,
  output logic                    axi_ar_ready,
  output logic [IdWidth-1:0]      axi_r_id,
  output logic [VecDataWidth-1:0] axi_r_data,
  output logic                    axi_r_valid,
  input  logic                    axi_r_ready,
  output logic [AddrWidth-1:0]    mem_req_addr,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  input  logic [MemDataWidth-1:0] mem_rsp_data,
  input  logic                    mem_rsp_valid
);

  localparam int N        = VecDataWidth / MemDataWidth;
  localparam int MemBytes = MemDataWidth / 8;
  localparam int OffW     = $clog2(MemBytes);
  localparam int CntW     = $clog2(N + 1);
  localparam int OutW     = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  state_t               state;
  logic [AddrWidth-1:0] base_q;
  logic [CntW-1:0]      issued;
  logic [CntW-1:0]      received;
  logic [OutW-1:0]      outstanding;

  logic                 req_fire;
  logic                 rsp_fire;
  logic [CntW-1:0]      issued_nxt;
  logic [CntW-1:0]      received_nxt;
  logic [OutW-1:0]      outstanding_nxt;
  logic                 req_valid_nxt;
  logic [AddrWidth-1:0] req_addr_nxt;
  logic [AddrWidth-1:0] ar_base;
  logic                 last_beat;

  assign axi_ar_ready = (state == IDLE);

  // A response that arrives with nothing in flight is stale (for example
  // one left over from a request abandoned by reset). It is dropped here.
  assign req_fire = mem_req_valid && mem_req_ready;
  assign rsp_fire = mem_rsp_valid && (outstanding != '0);

  // A grant and a response in the same cycle cancel out in the
  // outstanding count.
  assign issued_nxt      = issued + CntW'(req_fire);
  assign received_nxt    = received + CntW'(rsp_fire);
  assign outstanding_nxt = outstanding + OutW'(req_fire) - OutW'(rsp_fire);

  // The request outputs are registered, so they are computed from the
  // post-handshake counters. While stalled (valid && !ready), issued does
  // not move and outstanding can only fall, so valid and addr hold.
  assign req_valid_nxt = (issued_nxt < CntW'(N)) &&
                         (outstanding_nxt < OutW'(MaxOutstanding));
  assign req_addr_nxt  = base_q + (AddrWidth'(issued_nxt) << OffW);

  // The sub-beat address bits are ignored. Beat addresses wrap at the top
  // of the address space through plain modular addition.
  assign ar_base = axi_ar_addr & ~AddrWidth'(MemBytes - 1);

  assign last_beat = rsp_fire && (received_nxt == CntW'(N));

  // Single controller process. axi_r_id doubles as the latched request id,
  // and axi_r_data doubles as the reassembly buffer. Both are only
  // meaningful to the consumer while axi_r_valid is high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      base_q        <= '0;
      issued        <= '0;
      received      <= '0;
      outstanding   <= '0;
      axi_r_id      <= '0;
      axi_r_data    <= '0;
      axi_r_valid   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (axi_ar_valid) begin
            axi_r_id      <= axi_ar_id;
            base_q        <= ar_base;
            axi_r_data    <= '0;
            issued        <= '0;
            received      <= '0;
            outstanding   <= '0;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= ar_base;
            state         <= FETCH;
          end
        end

        FETCH: begin
          issued        <= issued_nxt;
          received      <= received_nxt;
          outstanding   <= outstanding_nxt;
          mem_req_valid <= req_valid_nxt;
          mem_req_addr  <= req_addr_nxt;
          if (rsp_fire) begin
            axi_r_data[int'(received) * MemDataWidth +: MemDataWidth] <= mem_rsp_data;
          end
          if (last_beat) begin
            mem_req_valid <= 1'b0;
            axi_r_valid   <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (axi_r_ready) begin
            axi_r_valid <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadac_vload_mem_rd.sv
// ---------------------------------------------------------------------------
// tb_xadac_vload_mem_rd
//
// Self-checking bench for xadac_vload_mem_rd (N = 256/64 = 4, two
// outstanding). A negedge monitor plays the memory and the R consumer. It
// keeps a transaction-level reference: the expected beat addresses, the
// expected vector built from a sparse memory image, and a count of beats in
// flight. Directed table entries, hand-written corner sequences and
// randomized requests are all checked against that reference.
// ---------------------------------------------------------------------------

module tb_xadac_vload_mem_rd;
  import xadac_pkg::*;

  localparam int MemDataWidth = 64;
  localparam int MaxOut       = 2;
  localparam int N            = VecDataWidth / MemDataWidth;
  localparam int MemBytes     = MemDataWidth / 8;
  localparam int VW           = VecDataWidth;

  logic                    clk;
  logic                    rstn;
  logic [IdWidth-1:0]      axi_ar_id;
  logic [AddrWidth-1:0]    axi_ar_addr;
  logic                    axi_ar_valid;
  logic                    axi_ar_ready;
  logic [IdWidth-1:0]      axi_r_id;
  logic [VecDataWidth-1:0] axi_r_data;
  logic                    axi_r_valid;
  logic                    axi_r_ready;
  logic [AddrWidth-1:0]    mem_req_addr;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [MemDataWidth-1:0] mem_rsp_data;
  logic                    mem_rsp_valid;

  xadac_vload_mem_rd #(
    .MemDataWidth  (MemDataWidth),
    .MaxOutstanding(MaxOut)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .axi_ar_id    (axi_ar_id),
    .axi_ar_addr  (axi_ar_addr),
    .axi_ar_valid (axi_ar_valid),
    .axi_ar_ready (axi_ar_ready),
    .axi_r_id     (axi_r_id),
    .axi_r_data   (axi_r_data),
    .axi_r_valid  (axi_r_valid),
    .axi_r_ready  (axi_r_ready),
    .mem_req_addr (mem_req_addr),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_valid(mem_rsp_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [VW-1:0] act,
                             input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Sparse memory image. Unwritten locations return an address hash.
  logic [MemDataWidth-1:0] memContents [logic [31:0]];

  function automatic logic [MemDataWidth-1:0] memRead(input logic [31:0] a);
    if (memContents.exists(a)) return memContents[a];
    return {a ^ 32'h5A5A_C3C3, (a * 32'd2654435761) ^ 32'h0F0F_1234};
  endfunction

  function automatic logic [VW-1:0] expVector(input logic [31:0] base);
    logic [VW-1:0] v;
    logic [31:0]   a;
    v = '0;
    for (int k = 0; k < N; k++) begin
      a = base + 32'(k * MemBytes);
      v[k*MemDataWidth +: MemDataWidth] = memRead(a);
    end
    return v;
  endfunction

  typedef struct { logic [3:0] id; logic [31:0] base; } planT;
  typedef struct { logic [31:0] addr; int neg; } pendT;
  typedef struct { logic [3:0] id; logic [VW-1:0] data; } expT;

  planT        planQ[$];
  pendT        pendQ[$];
  expT         expQ[$];
  logic [31:0] expAddrQ[$];

  // Knobs for the memory and R-consumer behaviour.
  bit randReady = 0;
  int rspProb   = 100;
  bit rspEnable = 1;
  int holdBeat  = -1;
  int holdLeft  = 0;
  int rLowLeft  = 0;
  bit rRandom   = 0;

  // Reference-model state and event timestamps (in negedge counts).
  int            negIdx = 0;
  bit            busy = 0;
  int            outModel = 0;
  int            staleCount = 0;
  int            reqGrantCount = 0;
  int            arHsNeg = 0;
  int            firstReqNeg = -1;
  int            firstRValidNeg = -1;
  int            lastRHsNeg = 0;
  int            lastArGap = 0;
  int            respCount = 0;
  logic [VW-1:0] lastRData = '0;
  logic [3:0]    lastRId = '0;

  // The memory, the R consumer and the reference model all run on the
  // negedge. The ready/response inputs are driven first, and then the
  // handshakes that will complete at the next posedge are observed.
  initial begin
    pendT          p;
    planT          pl;
    expT           e;
    bit            prevStall;
    bit            prevRStall;
    logic [31:0]   prevAddr;
    logic [3:0]    prevRId;
    logic [VW-1:0] prevRData;
    int            outBefore;
    prevStall = 0;
    prevRStall = 0;
    prevAddr = '0;
    prevRId = '0;
    prevRData = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    axi_r_ready = 1'b0;
    forever begin
      @(negedge clk);
      negIdx++;
      outBefore = outModel;

      if (holdBeat >= 0 && reqGrantCount == holdBeat && holdLeft > 0) begin
        mem_req_ready = 1'b0;
        holdLeft--;
      end else if (randReady) mem_req_ready = ($urandom_range(0, 1) == 1);
      else mem_req_ready = 1'b1;

      mem_rsp_valid = 1'b0;
      if (rspEnable && pendQ.size() > 0 && pendQ[0].neg < negIdx &&
          int'($urandom_range(1, 100)) <= rspProb) begin
        p = pendQ.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data = memRead(p.addr);
        if (staleCount > 0) staleCount--;
        else outModel--;
      end

      if (axi_r_valid && rLowLeft > 0) begin
        axi_r_ready = 1'b0;
        rLowLeft--;
      end else if (rRandom) axi_r_ready = ($urandom_range(0, 1) == 1);
      else axi_r_ready = 1'b1;

      checkOutput("ar_ready", VW'(axi_ar_ready), VW'(!busy));
      if (prevStall) begin
        checkOutput("req_valid_hold", VW'(mem_req_valid), VW'(1));
        checkOutput("req_addr_hold", VW'(mem_req_addr), VW'(prevAddr));
      end
      if (prevRStall) begin
        checkOutput("r_valid_hold", VW'(axi_r_valid), VW'(1));
        checkOutput("r_id_hold", VW'(axi_r_id), VW'(prevRId));
        checkOutput("r_data_hold", axi_r_data, prevRData);
      end

      if (rstn) begin
        if (mem_req_valid && mem_req_ready) begin
          if (expAddrQ.size() == 0) flagFail("extra_mem_grant");
          else checkOutput("mem_req_addr", VW'(mem_req_addr), VW'(expAddrQ.pop_front()));
          checkOutput("outstanding_limit", VW'(outBefore < MaxOut), VW'(1));
          pendQ.push_back('{mem_req_addr, negIdx});
          outModel++;
          reqGrantCount++;
          if (firstReqNeg < 0) firstReqNeg = negIdx;
        end
        if (axi_r_valid && firstRValidNeg < 0) firstRValidNeg = negIdx;
        if (axi_r_valid && axi_r_ready) begin
          if (expQ.size() == 0) flagFail("extra_r_response");
          else begin
            e = expQ.pop_front();
            checkOutput("r_id", VW'(axi_r_id), VW'(e.id));
            checkOutput("r_data", axi_r_data, e.data);
          end
          checkOutput("beats_left_at_r", VW'(expAddrQ.size()), VW'(0));
          lastRData = axi_r_data;
          lastRId = axi_r_id;
          lastRHsNeg = negIdx;
          busy = 0;
          respCount++;
        end
        if (axi_ar_valid && axi_ar_ready) begin
          if (planQ.size() == 0) flagFail("unplanned_ar");
          else begin
            pl = planQ.pop_front();
            expQ.push_back('{pl.id, expVector(pl.base)});
            for (int k = 0; k < N; k++) expAddrQ.push_back(pl.base + 32'(k * MemBytes));
          end
          busy = 1;
          reqGrantCount = 0;
          arHsNeg = negIdx;
          lastArGap = negIdx - lastRHsNeg;
          firstReqNeg = -1;
          firstRValidNeg = -1;
        end
        prevStall = mem_req_valid && !mem_req_ready;
        prevAddr = mem_req_addr;
        prevRStall = axi_r_valid && !axi_r_ready;
        prevRId = axi_r_id;
        prevRData = axi_r_data;
      end else begin
        // The next posedge resets the DUT. Whatever is still in flight
        // becomes stale and must be ignored.
        busy = 0;
        expQ.delete();
        expAddrQ.delete();
        outModel = 0;
        staleCount = pendQ.size();
        prevStall = 0;
        prevRStall = 0;
      end
    end
  end

  // Presents one AR and holds it until accepted. It is entered and left at
  // posedge+1.
  task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr,
                               input logic [31:0] base);
    int waited;
    waited = 0;
    planQ.push_back('{id, base});
    axi_ar_id = id;
    axi_ar_addr = addr;
    axi_ar_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (axi_ar_ready) break;
      waited++;
      if (waited > 300) begin
        flagFail("ar_accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    axi_ar_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!busy && expQ.size() == 0 && pendQ.size() == 0 && !axi_r_valid) break;
      waited++;
      if (waited > 2000) begin
        flagFail("idle_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] expBase;
    int          rLow;
    int          expRValidLat;
    int          expRHsLat;
  } vecT;

  vecT vecs [5];

  initial begin
    logic [31:0] addr;
    logic [31:0] base;
    int          waited;

    vecs[0] = '{4'd3,  32'h0000_1000, 32'h0000_1000, 0, 6, 6};
    vecs[1] = '{4'd7,  32'hFFFF_FFF5, 32'hFFFF_FFF0, 1, 6, 7};
    vecs[2] = '{4'd9,  32'h0000_2003, 32'h0000_2000, 0, 6, 6};
    vecs[3] = '{4'd0,  32'h0000_0007, 32'h0000_0000, 2, 6, 8};
    vecs[4] = '{4'd15, 32'h8000_00FF, 32'h8000_00F8, 0, 6, 6};

    memContents[32'h0000_1000] = 64'h1111_1111_1111_1111;
    memContents[32'h0000_1008] = 64'h2222_2222_2222_2222;
    memContents[32'h0000_1010] = 64'h3333_3333_3333_3333;
    memContents[32'h0000_1018] = 64'h4444_4444_4444_4444;

    rstn = 1'b0;
    axi_ar_valid = 1'b0;
    axi_ar_id = '0;
    axi_ar_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_r_valid", VW'(axi_r_valid), VW'(0));
    checkOutput("reset_r_id", VW'(axi_r_id), VW'(0));
    checkOutput("reset_r_data", axi_r_data, VW'(0));
    checkOutput("reset_req_valid", VW'(mem_req_valid), VW'(0));
    checkOutput("reset_req_addr", VW'(mem_req_addr), VW'(0));
    checkOutput("reset_ar_ready", VW'(axi_ar_ready), VW'(1));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: min-latency memory, R ready after rLow cycles.
    $display("[TB] directed table");
    for (int i = 0; i < 5; i++) begin
      rLowLeft = vecs[i].rLow;
      applyStimulus(vecs[i].id, vecs[i].addr, vecs[i].expBase);
      waitIdle();
      checkOutput("first_req_latency", VW'(firstReqNeg - arHsNeg), VW'(1));
      checkOutput("r_valid_latency", VW'(firstRValidNeg - arHsNeg), VW'(vecs[i].expRValidLat));
      checkOutput("r_handshake_latency", VW'(lastRHsNeg - arHsNeg), VW'(vecs[i].expRHsLat));
      if (i == 0) begin
        checkOutput("single_lane0", VW'(lastRData[63:0]), VW'(64'h1111_1111_1111_1111));
        checkOutput("single_lane3", VW'(lastRData[255:192]), VW'(64'h4444_4444_4444_4444));
      end
    end

    // Backpressure: the third beat stalls for 3 cycles, and R stalls for 5.
    $display("[TB] backpressure");
    holdBeat = 2;
    holdLeft = 3;
    rLowLeft = 5;
    applyStimulus(4'd4, 32'h0000_4000, 32'h0000_4000);
    waitIdle();
    checkOutput("bp_hold_used", VW'(holdLeft), VW'(0));
    checkOutput("bp_r_valid_latency", VW'(firstRValidNeg - arHsNeg), VW'(9));
    checkOutput("bp_r_handshake_latency", VW'(lastRHsNeg - arHsNeg), VW'(14));
    holdBeat = -1;

    // Back-to-back: the second AR is held while the first is in flight.
    $display("[TB] back-to-back");
    applyStimulus(4'd1, 32'h0000_5000, 32'h0000_5000);
    applyStimulus(4'd2, 32'h0000_6010, 32'h0000_6010);
    checkOutput("b2b_ar_gap", VW'(lastArGap), VW'(1));
    waitIdle();
    checkOutput("b2b_last_id", VW'(lastRId), VW'(2));

    // Reset mid-FETCH with two beats outstanding and no responses yet.
    $display("[TB] reset mid-fetch");
    rspEnable = 0;
    applyStimulus(4'd6, 32'h0000_3000, 32'h0000_3000);
    waited = 0;
    while (reqGrantCount < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("pre_reset_grants", VW'(reqGrantCount), VW'(2));
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("mid_reset_r_valid", VW'(axi_r_valid), VW'(0));
    checkOutput("mid_reset_r_id", VW'(axi_r_id), VW'(0));
    checkOutput("mid_reset_r_data", axi_r_data, VW'(0));
    checkOutput("mid_reset_req_valid", VW'(mem_req_valid), VW'(0));
    checkOutput("mid_reset_req_addr", VW'(mem_req_addr), VW'(0));
    checkOutput("mid_reset_ar_ready", VW'(axi_ar_ready), VW'(1));
    rspEnable = 1;
    waited = 0;
    while (pendQ.size() > 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    checkOutput("stale_ignored_req_valid", VW'(mem_req_valid), VW'(0));
    checkOutput("stale_ignored_ar_ready", VW'(axi_ar_ready), VW'(1));
    applyStimulus(4'd5, 32'h0000_3000, 32'h0000_3000);
    waitIdle();
    checkOutput("post_reset_id", VW'(lastRId), VW'(5));
    checkOutput("post_reset_data", lastRData, expVector(32'h0000_3000));

    // Randomized requests with random memory and R backpressure.
    $display("[TB] random");
    randReady = 1;
    rRandom = 1;
    for (int i = 0; i < 40; i++) begin
      rspProb = int'($urandom_range(20, 100));
      addr = $urandom();
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      base = addr - (addr % 32'(MemBytes));
      applyStimulus(4'($urandom_range(0, 15)), addr, base);
      waitIdle();
    end
    checkOutput("total_responses", VW'(respCount), VW'(5 + 1 + 2 + 1 + 40));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
